// File: rtl/noc_egress_spi_if.sv
// NoC-side packet handshake into the egress bridge.
interface noc_egress_spi_if;
   logic [31:0] packet_in;
   logic        packet_valid;
   logic        packet_ready;

   // NoC source side
   modport master (
      output packet_in,
      output packet_valid,
      input  packet_ready
   );

   // Egress bridge side
   modport slave (
      input  packet_in,
      input  packet_valid,
      output packet_ready
   );
endinterface

// File: rtl/noc_egress_spi.sv
// NoC-to-host egress bridge: small packet FIFO drained by an SPI mode-0
// responder (8-bit command in, 32-bit response out, MSB first).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | csb high or frame finished; waiting for a synced csb fall
// CMD   | shifting the 8 command bits in on sclk rises
// RESP  | shifting the 32-bit response out on sclk falls
// DONE  | 40 rises seen; edges ignored, miso held at 0 until csb rises
module noc_egress_spi #(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   noc_egress_spi_if.slave noc,
   input  logic            host_sclk,
   input  logic            host_csb,
   input  logic            host_mosi,
   output logic            host_miso,
   output logic            host_miso_oe,
   output logic [7:0]      fifo_level,
   output logic            underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [7:0] CMD_READ_PKT = 8'h03;
   localparam logic [7:0] CMD_STATUS   = 8'h05;

   typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;

   // synchronizers and edge detect
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] csb_sync_q,  csb_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   csb_prev_q,  csb_prev_d;
   logic                   sclk_s, csb_s, mosi_s;
   logic                   sclk_rise, sclk_fall, csb_fall;

   // FSM
   state_t      state_q, state_d;
   logic [6:0]  cmd_q, cmd_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] shift_q, shift_d;
   logic        miso_q, miso_d;
   logic        oe_q, oe_d;
   logic [7:0]  cmd_full;
   logic        decode;
   logic [31:0] load_word;

   // FIFO
   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          underflow_q, underflow_d;
   logic          push, pop, fifo_empty;

   assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], host_sclk};
   assign csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0],  host_csb};
   assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], host_mosi};

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign csb_s  = csb_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign sclk_prev_d = sclk_s;
   assign csb_prev_d  = csb_s;

   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign csb_fall  = ~csb_s & csb_prev_q;

   // SPI pin synchronizers; idle bus values out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q <= '0;
         csb_sync_q  <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         csb_prev_q  <= 1'b1;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         csb_sync_q  <= csb_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_prev_q <= sclk_prev_d;
         csb_prev_q  <= csb_prev_d;
      end
   end

   assign fifo_empty = (level_q == '0);
   assign cmd_full   = {cmd_q, mosi_s};

   // response word selected by the fully assembled command
   always_comb begin
      load_word = 32'h0;
      if (cmd_full == CMD_READ_PKT) begin
         load_word = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
      end else if (cmd_full == CMD_STATUS) begin
         load_word = {16'h0, underflow_q, 7'h0, fifo_level};
      end
   end

   // FSM next state, shift register and registered SPI outputs
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      miso_d    = miso_q;
      decode    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (csb_fall) begin
               state_d   = CMD;
               bit_cnt_d = '0;
            end
         end
         CMD: begin
            if (sclk_rise) begin
               cmd_d     = cmd_full[6:0];
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd7 && !csb_s) begin
                  decode  = 1'b1;
                  shift_d = load_word;
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (sclk_fall) begin
               miso_d  = shift_q[31];
               shift_d = {shift_q[30:0], 1'b0};
            end
            if (sclk_rise) begin
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd39) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
         end
         default: state_d = IDLE;
      endcase
      if (csb_s) begin
         state_d = IDLE;
      end
      oe_d = (state_d == RESP) || (state_d == DONE);
      if (!oe_d || state_d == DONE) begin
         miso_d = 1'b0;
      end
   end

   // FSM registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cmd_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         miso_q    <= 1'b0;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         miso_q    <= miso_d;
         oe_q      <= oe_d;
      end
   end

   assign host_miso    = miso_q;
   assign host_miso_oe = oe_q;

   // FIFO pointer/level update and sticky underflow; a pop at decode is final
   always_comb begin
      push        = noc.packet_valid && (level_q != LW'(DEPTH));
      pop         = decode && (cmd_full == CMD_READ_PKT) && !fifo_empty;
      wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d     = level_q + LW'(push) - LW'(pop);
      underflow_d = underflow_q;
      if (decode && cmd_full == CMD_STATUS) begin
         underflow_d = 1'b0;
      end
      if (decode && cmd_full == CMD_READ_PKT && fifo_empty) begin
         underflow_d = 1'b1;
      end
   end

   // FIFO bookkeeping registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         underflow_q <= underflow_d;
      end
   end

   // FIFO storage; contents are don't-care while the level says empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= noc.packet_in;
      end
   end

   assign noc.packet_ready = (level_q != LW'(DEPTH));
   assign fifo_level       = 8'(level_q);
   assign underflow        = underflow_q;

endmodule

// File: tb/tb_noc_egress_spi.sv
// Directed bench for noc_egress_spi: NoC pushes plus host SPI frames.
module tb_noc_egress_spi;

   localparam int HALF = 80;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        host_sclk = 1'b0;
   logic        host_csb = 1'b1;
   logic        host_mosi = 1'b0;
   logic        host_miso;
   logic        host_miso_oe;
   logic [7:0]  fifo_level;
   logic        underflow;

   int n_cmp = 0;
   int n_bad = 0;

   logic        oe_in_cmd;
   logic        oe_in_resp;
   logic        miso_at_end;
   logic        oe_at_end;
   logic [31:0] rsp;

   noc_egress_spi_if nif ();

   noc_egress_spi #(.DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .noc          (nif.slave),
      .host_sclk    (host_sclk),
      .host_csb     (host_csb),
      .host_mosi    (host_mosi),
      .host_miso    (host_miso),
      .host_miso_oe (host_miso_oe),
      .fifo_level   (fifo_level),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] d);
      @(negedge clk);
      nif.packet_valid = 1'b1;
      nif.packet_in    = d;
      @(negedge clk);
      nif.packet_valid = 1'b0;
   endtask

   task automatic spi_begin();
      @(negedge clk);
      host_sclk = 1'b0;
      host_csb  = 1'b0;
      #200;
   endtask

   task automatic spi_cmd(input logic [7:0] cmd);
      oe_in_cmd = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         host_mosi = cmd[i];
         #HALF;
         oe_in_cmd = oe_in_cmd | host_miso_oe;
         host_sclk = 1'b1;
         #HALF;
         host_sclk = 1'b0;
      end
      host_mosi = 1'b0;
   endtask

   task automatic spi_resp(input int nbits, output logic [31:0] data);
      data       = '0;
      oe_in_resp = 1'b1;
      for (int i = 0; i < nbits; i++) begin
         #HALF;
         host_sclk  = 1'b1;
         data       = {data[30:0], host_miso};
         oe_in_resp = oe_in_resp & host_miso_oe;
         #HALF;
         host_sclk  = 1'b0;
      end
   endtask

   task automatic spi_end();
      #200;
      miso_at_end = host_miso;
      oe_at_end   = host_miso_oe;
      host_csb    = 1'b1;
      #300;
   endtask

   task automatic spi_frame(input logic [7:0] cmd, output logic [31:0] data);
      spi_begin();
      spi_cmd(cmd);
      spi_resp(32, data);
      spi_end();
   endtask

   initial begin
      nif.packet_valid = 1'b0;
      nif.packet_in    = '0;

      // reset values
      #23;
      check_val("rst_ready", 32'(nif.packet_ready), 32'd1);
      check_val("rst_level", 32'(fifo_level), 32'd0);
      check_val("rst_underflow", 32'(underflow), 32'd0);
      check_val("rst_miso", 32'(host_miso), 32'd0);
      check_val("rst_oe", 32'(host_miso_oe), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // push then read
      push(32'hDEADBEEF);
      push(32'h12345678);
      @(negedge clk);
      check_val("level_after_2push", 32'(fifo_level), 32'd2);
      spi_frame(8'h03, rsp);
      check_val("read1_data", rsp, 32'hDEADBEEF);
      check_val("read1_level", 32'(fifo_level), 32'd1);
      check_val("done_miso_zero", 32'(miso_at_end), 32'd0);
      check_val("done_oe_high", 32'(oe_at_end), 32'd1);
      check_val("oe_low_after_csb", 32'(host_miso_oe), 32'd0);
      spi_frame(8'h03, rsp);
      check_val("read2_data", rsp, 32'h12345678);
      check_val("read2_level", 32'(fifo_level), 32'd0);

      // full
      for (int i = 0; i < 4; i++) push(32'h11110001 + 32'(i));
      @(negedge clk);
      check_val("full_level", 32'(fifo_level), 32'd4);
      check_val("full_ready", 32'(nif.packet_ready), 32'd0);
      nif.packet_valid = 1'b1;
      nif.packet_in    = 32'h55555555;
      repeat (5) @(negedge clk);
      check_val("held_level", 32'(fifo_level), 32'd4);
      spi_frame(8'h03, rsp);
      check_val("full_read_data", rsp, 32'h11110001);
      check_val("held_accepted_level", 32'(fifo_level), 32'd4);
      check_val("held_accepted_ready", 32'(nif.packet_ready), 32'd0);
      @(negedge clk);
      nif.packet_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         spi_frame(8'h03, rsp);
         check_val("drain_data", rsp, 32'h11110001 + 32'(i));
      end
      spi_frame(8'h03, rsp);
      check_val("drain_held_data", rsp, 32'h55555555);
      check_val("drain_level", 32'(fifo_level), 32'd0);
      check_val("drain_no_uf", 32'(underflow), 32'd0);

      // underflow and status
      spi_frame(8'h03, rsp);
      check_val("uf_read_data", rsp, 32'h0);
      check_val("uf_flag_set", 32'(underflow), 32'd1);
      spi_frame(8'h05, rsp);
      check_val("status1", rsp, 32'h00008000);
      check_val("uf_flag_cleared", 32'(underflow), 32'd0);
      spi_frame(8'h05, rsp);
      check_val("status2", rsp, 32'h00000000);

      // abort after 12 response bits
      push(32'hA5A5A5A5);
      spi_begin();
      spi_cmd(8'h03);
      spi_resp(12, rsp);
      spi_end();
      check_val("abort_partial", rsp, 32'h00000A5A);
      check_val("abort_level", 32'(fifo_level), 32'd0);
      check_val("abort_oe", 32'(host_miso_oe), 32'd0);
      spi_frame(8'h05, rsp);
      check_val("abort_status", rsp, 32'h00000000);
      spi_frame(8'h03, rsp);
      check_val("abort_lost", rsp, 32'h0);
      check_val("abort_uf", 32'(underflow), 32'd1);
      spi_frame(8'h05, rsp);
      check_val("abort_status_uf", rsp, 32'h00008000);

      // unknown command with two packets queued
      push(32'hCAFE0001);
      push(32'hCAFE0002);
      spi_frame(8'hFF, rsp);
      check_val("unk_data", rsp, 32'h0);
      check_val("unk_level", 32'(fifo_level), 32'd2);
      check_val("unk_oe_cmd", 32'(oe_in_cmd), 32'd0);
      check_val("unk_oe_resp", 32'(oe_in_resp), 32'd1);
      check_val("unk_oe_after", 32'(host_miso_oe), 32'd0);
      spi_frame(8'h05, rsp);
      check_val("unk_status", rsp, 32'h00000002);

      // reset in the middle of a response
      spi_begin();
      spi_cmd(8'h03);
      spi_resp(5, rsp);
      check_val("pre_rst_bits", rsp, 32'h00000019);
      check_val("pre_rst_level", 32'(fifo_level), 32'd1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_val("midrst_oe", 32'(host_miso_oe), 32'd0);
      check_val("midrst_miso", 32'(host_miso), 32'd0);
      check_val("midrst_level", 32'(fifo_level), 32'd0);
      check_val("midrst_ready", 32'(nif.packet_ready), 32'd1);
      check_val("midrst_uf", 32'(underflow), 32'd0);
      host_csb  = 1'b1;
      host_sclk = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      spi_frame(8'h03, rsp);
      check_val("postrst_data", rsp, 32'h0);
      check_val("postrst_uf", 32'(underflow), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
